spi_slave_if: RTL
=================

// Module: spi_slave_if
// PURPOSE
//  SPI slave endpoint: receive/transmit peer for the SPI master, on the consumer side of the link.
//  Oversamples SCLK/SS/MOSI in the system clock domain; no logic is clocked by SCLK.
//  Deserialises MOSI into bytes for the local consumer.
//  Serialises a locally supplied byte onto MISO, full duplex, MSB first.
// PARAMETERS
//  SPI_MODE     3      CPOL=(MODE>=2), CPHA=(MODE odd); must match the master
//  SYNC_STAGES  2      flops per input synchroniser (SCLK, SS_n, MOSI), >=2
//  IDLE_BYTE    8'hFF  byte shifted out on MISO when no TX byte is pending
// PORTS
//  clk          in   1  system clock; SCLK frequency <= clk/8
//  rst          in   1  synchronous, active-high reset
//  i_SPI_Clk    in   1  SCLK from master, asynchronous
//  i_SS_n       in   1  slave select, active-low, asynchronous
//  i_SPI_MOSI   in   1  MOSI line, asynchronous
//  o_SPI_MISO   out  1  MISO data
//  o_MISO_En    out  1  MISO output enable (1 while selected)
//  i_TX_Byte    in   8  next byte to send
//  i_TX_DV      in   1  i_TX_Byte valid; accepted only when o_TX_Ready=1
//  o_TX_Ready   out  1  TX holding register empty
//  o_RX_Byte    out  8  last complete received byte
//  o_RX_DV      out  1  1-clk pulse: o_RX_Byte updated
//  o_Frame_Err  out  1  1-clk pulse: SS_n released mid-byte
// BEHAVIOUR
//  Reset: all outputs 0, except o_TX_Ready=1; FSM=IDLE, bit count=0, holding reg empty.
//  Sync: each input passes SYNC_STAGES flops, plus one history flop for SCLK/SS edge detection.
//  Sample edge: rising in modes 0 and 3, falling in modes 1 and 2. Shift edge is the opposite edge.
//  FSM IDLE: o_MISO_En=0, o_SPI_MISO=0. Synced SS_n falling -> LOAD.
//  FSM LOAD (1 clk): shift reg <= holding reg if full (holding -> empty), else IDLE_BYTE.
//    Bit cnt=0; o_MISO_En=1. CPHA=0: MISO=MSB now. CPHA=1: MISO set on first shift edge.
//    -> ACTIVE.
//  FSM ACTIVE, sample edge: rx shift <= {rx[6:0],MOSI_sync}; bit cnt++.
//    On the 8th sample: o_RX_Byte <= assembled byte, o_RX_DV=1 for exactly 1 clk.
//    RX_DV latency: SYNC_STAGES+2 clk after the pin-level 8th sample edge.
//  FSM ACTIVE, shift edge: MISO <= next bit.
//    CPHA=0: the shift edge following the 8th sample reloads the shift reg (holding or IDLE_BYTE)
//      and drives the new MSB.
//    CPHA=1: the reload happens at the 8th sample; the next shift edge drives the new MSB.
//  Back-to-back bytes within one SS frame: no idle bits; bit cnt wraps 7->0.
//  TX holding: i_TX_DV & o_TX_Ready -> latch byte, o_TX_Ready=0 next clk.
//    Ready returns to 1 the clk after the byte is moved into the shift reg.
//    i_TX_DV while o_TX_Ready=0: ignored, holding byte unchanged.
//  Underrun: holding empty at reload -> IDLE_BYTE sent, no error flag.
//  SS_n rising in ACTIVE -> IDLE next clk.
//    Bit cnt !=0: partial byte discarded, no RX_DV, o_Frame_Err=1 for 1 clk.
//    Bit cnt ==0: clean end. Holding reg keeps any pending byte.
//  Simultaneous: SS rise and 8th sample edge detected in the same clk -> byte completes (RX_DV=1),
//    no Frame_Err. SS_n fall while in LOAD: ignored.
//  Edges seen in IDLE are ignored. rst mid-frame: everything returns to reset values next clk;
//    holding reg emptied.
// TESTING
//  1 Mode 3, clk/8 SCLK, master sends 8'hA5 -> one o_RX_DV pulse, o_RX_Byte=8'hA5,
//    latency SYNC_STAGES+2 from 8th rising edge.
//  2 i_TX_DV with 8'h3C before SS_n falls -> master receives 8'h3C; o_TX_Ready 0 then 1 after LOAD.
//  3 One SS frame, 2 bytes 8'h12,8'h34 while slave sends 8'hC3 then nothing
//    -> RX_DV twice (12,34); MISO bytes C3,FF.
//  4 SS_n released after 5 bits -> o_Frame_Err one pulse, no RX_DV, o_RX_Byte unchanged,
//    next frame 8'h5A received correctly.
//  5 Repeat 1-3 in mode 0 -> identical byte results; MISO MSB valid before the first rising SCLK.
//  6 rst asserted at bit 4, then new frame 8'h81
//    -> reset values 1 clk after rst; 8'h81 received; MISO sends IDLE_BYTE.

Source files
------------

// File: rtl/spi_slave_if.sv
// SPI slave endpoint: oversamples SCLK/SS_n/MOSI in the clk domain, full-duplex byte
// exchange with a one-deep TX holding register.
module spi_slave_if #(
    parameter int unsigned SPI_MODE    = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_SPI_Clk,
    input  logic       i_SS_n,
    input  logic       i_SPI_MOSI,
    output logic       o_SPI_MISO,
    output logic       o_MISO_En,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_DV,
    output logic       o_Frame_Err
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam logic CPOL = (SPI_MODE >= 2);
    localparam logic CPHA = ((SPI_MODE % 2) == 1);
    localparam logic SAMPLE_ON_RISE = (CPOL == CPHA);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ACTIVE} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic                   sclk_hist, ss_hist;
    logic                   sclk_s, ss_s, mosi_s;
    logic                   sclk_rise, sclk_fall, ss_fall;
    logic                   sample_ev, shift_ev, byte_done, reload, ending;
    logic [CNT_W-1:0]       bit_cnt, cnt_after;
    logic [BYTE_W-1:0]      rx_shift, tx_shift, hold_byte, next_tx;
    logic                   rx_full;

    // Input synchronisers; reset to the idle bus levels so no edge is seen out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= {SYNC_STAGES{CPOL}};
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_hist <= CPOL;
            ss_hist   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_SPI_Clk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], i_SS_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_SPI_MOSI};
            sclk_hist <= sclk_sync[SYNC_STAGES-1];
            ss_hist   <= ss_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist;
    assign sclk_fall = ~sclk_s & sclk_hist;
    assign ss_fall   = ~ss_s & ss_hist;

    assign sample_ev = (state == S_ACTIVE) && (SAMPLE_ON_RISE ? sclk_rise : sclk_fall);
    assign shift_ev  = (state == S_ACTIVE) && (SAMPLE_ON_RISE ? sclk_fall : sclk_rise);
    assign ending    = (state == S_ACTIVE) && ss_s;
    assign byte_done = sample_ev && (bit_cnt == CNT_W'(7));
    assign cnt_after = sample_ev ? bit_cnt + CNT_W'(1) : bit_cnt;
    assign next_tx   = o_TX_Ready ? IDLE_BYTE : hold_byte;
    // CPHA=1 reloads on the 8th sample; CPHA=0 on the shift edge that follows it
    assign reload    = !ending && (CPHA ? byte_done : (shift_ev && (bit_cnt == '0)));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (ss_fall) state_nxt = S_LOAD;
            S_LOAD:   state_nxt = S_ACTIVE;
            S_ACTIVE: if (ss_s) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Shift datapath, TX holding register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            hold_byte   <= '0;
            rx_full     <= 1'b0;
            o_SPI_MISO  <= 1'b0;
            o_MISO_En   <= 1'b0;
            o_TX_Ready  <= 1'b1;
            o_RX_Byte   <= '0;
            o_RX_DV     <= 1'b0;
            o_Frame_Err <= 1'b0;
        end else begin
            rx_full     <= 1'b0;
            o_RX_DV     <= rx_full;
            o_Frame_Err <= 1'b0;
            if (rx_full) o_RX_Byte <= rx_shift;
            if (i_TX_DV && o_TX_Ready) begin
                hold_byte  <= i_TX_Byte;
                o_TX_Ready <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    bit_cnt    <= '0;
                    o_MISO_En  <= 1'b0;
                    o_SPI_MISO <= 1'b0;
                end
                S_LOAD: begin
                    bit_cnt   <= '0;
                    o_MISO_En <= 1'b1;
                    if (!o_TX_Ready) o_TX_Ready <= 1'b1;
                    if (CPHA) begin
                        tx_shift <= next_tx;
                    end else begin
                        tx_shift   <= {next_tx[BYTE_W-2:0], 1'b0};
                        o_SPI_MISO <= next_tx[BYTE_W-1];
                    end
                end
                S_ACTIVE: begin
                    if (sample_ev) begin
                        rx_shift <= {rx_shift[BYTE_W-2:0], mosi_s};
                        bit_cnt  <= cnt_after;
                    end
                    rx_full <= byte_done;
                    if (ending) begin
                        o_Frame_Err <= (cnt_after != '0);
                        o_MISO_En   <= 1'b0;
                        o_SPI_MISO  <= 1'b0;
                        bit_cnt     <= '0;
                    end else if (reload) begin
                        if (!o_TX_Ready) o_TX_Ready <= 1'b1;
                        if (CPHA) begin
                            tx_shift <= next_tx;
                        end else begin
                            tx_shift   <= {next_tx[BYTE_W-2:0], 1'b0};
                            o_SPI_MISO <= next_tx[BYTE_W-1];
                        end
                    end else if (shift_ev) begin
                        o_SPI_MISO <= tx_shift[BYTE_W-1];
                        tx_shift   <= {tx_shift[BYTE_W-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
